// File: rtl/salamander_pkg.sv
// Shared definitions for the Salamander boot path: loader FSM states and the
// default word/address widths used by the instruction memory.
package salamander_pkg;

  localparam int SIZE_DEF   = 8;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    RUN,
    ERR
  } loader_state_e;

endpackage

// File: rtl/ldr_checksum.sv
// Modulo-2**SIZE running sum of payload beats, with a compare against a
// candidate checksum beat.
module ldr_checksum #(
  parameter int SIZE = salamander_pkg::SIZE_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr,
  input  logic            en,
  input  logic [SIZE-1:0] data,
  input  logic [SIZE-1:0] cmp,
  output logic [SIZE-1:0] sum,
  output logic            match
);

  logic [SIZE-1:0] sum_reg;

  // clr wins over en so a restart never folds a stray beat into the new sum
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum_reg <= '0;
    end else if (clr) begin
      sum_reg <= '0;
    end else if (en) begin
      sum_reg <= sum_reg + data;
    end
  end

  assign sum   = sum_reg;
  assign match = (cmp == sum_reg);

endmodule

// File: rtl/prog_loader.sv
// Boot-time program writer: takes a length/payload/checksum byte stream,
// writes the payload to instruction memory and releases the CPU on success.
module prog_loader
  import salamander_pkg::*;
#(
  parameter int SIZE   = SIZE_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              in_valid,
  input  logic [SIZE-1:0]   in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [SIZE-1:0]   mem_wdata,
  output logic              cpu_rstn,
  output logic              done,
  output logic              error
);

  localparam int DEPTH = 2 ** ADDR_W;

  loader_state_e     state_reg, state_next;
  logic [ADDR_W-1:0] count_reg, count_next;
  logic [ADDR_W:0]   len_reg, len_next;
  logic              in_ready_reg, in_ready_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [SIZE-1:0]   mem_wdata_reg, mem_wdata_next;
  logic              cpu_rstn_reg, cpu_rstn_next;
  logic              done_reg, done_next;
  logic              error_reg, error_next;
  logic              sum_clr, sum_en, sum_match;
  logic [SIZE-1:0]   sum_val;
  logic              xfer;

  // a beat offered in the same cycle as start is deliberately dropped
  assign xfer = in_valid & in_ready_reg & ~start;

  ldr_checksum #(.SIZE(SIZE)) u_csum (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (sum_clr),
    .en    (sum_en),
    .data  (in_data),
    .cmp   (in_data),
    .sum   (sum_val),
    .match (sum_match)
  );

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    len_next       = len_reg;
    sum_clr        = 1'b0;
    sum_en         = 1'b0;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    if (start) begin
      state_next = LEN;
      count_next = '0;
      sum_clr    = 1'b1;
    end else begin
      case (state_reg)
        LEN: if (xfer) begin
          if (in_data == '0 || 32'(in_data) > DEPTH) begin
            state_next = ERR;
          end else begin
            len_next   = in_data[ADDR_W:0];
            count_next = '0;
            sum_clr    = 1'b1;
            state_next = DATA;
          end
        end
        DATA: if (xfer) begin
          mem_we_next    = 1'b1;
          mem_addr_next  = count_reg;
          mem_wdata_next = in_data;
          sum_en         = 1'b1;
          // count holds at the last address so mem_addr never wraps
          if ({1'b0, count_reg} == len_reg - 1'b1) begin
            state_next = CSUM;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
        CSUM: if (xfer) begin
          state_next = sum_match ? RUN : ERR;
        end
        default: ;
      endcase
    end
    in_ready_next = (state_next == LEN) || (state_next == DATA) || (state_next == CSUM);
    cpu_rstn_next = (state_next == RUN);
    done_next     = (state_next == RUN);
    error_next    = (state_next == ERR);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      len_reg       <= '0;
      in_ready_reg  <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      cpu_rstn_reg  <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      len_reg       <= len_next;
      in_ready_reg  <= in_ready_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      cpu_rstn_reg  <= cpu_rstn_next;
      done_reg      <= done_next;
      error_reg     <= error_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign cpu_rstn  = cpu_rstn_reg;
  assign done      = done_reg;
  assign error     = error_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: nominal load, bad checksum, length bounds,
// stalls, restart and asynchronous reset, with a write-port log.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_rstn;
  logic       done;
  logic       error;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [3:0] wa[$];
  logic [7:0] wd[$];
  int         wc[$];

  prog_loader #(.SIZE(8), .ADDR_W(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rstn  (cpu_rstn),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_abc(input string tag, input int step);
    chk({tag, "_nwr"}, wa.size(), 32'd3);
    if (wa.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("%s_addr%0d", tag, i), 32'(wa[i]), 32'(i));
        chk($sformatf("%s_data%0d", tag, i), 32'(wd[i]), 32'(8'h11 * (i + 1)));
      end
      chk({tag, "_gap01"}, wc[1] - wc[0], 32'(step));
      chk({tag, "_gap12"}, wc[2] - wc[1], 32'(step));
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_cpu_rstn", 32'(cpu_rstn), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_in_ready", 32'(in_ready), 0);

    // nominal back-to-back load
    clear_log();
    pulse_start();
    chk("nom_len_ready", 32'(in_ready), 1);
    send(8'h03, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    chk("nom_done_pre", 32'(done), 0);
    send(8'h66, 0);
    chk("nom_done", 32'(done), 1);
    chk("nom_cpu_rstn", 32'(cpu_rstn), 1);
    chk("nom_in_ready", 32'(in_ready), 0);
    check_abc("nom", 1);

    // restart out of RUN
    pulse_start();
    chk("rrun_done", 32'(done), 0);
    chk("rrun_cpu_rstn", 32'(cpu_rstn), 0);
    chk("rrun_in_ready", 32'(in_ready), 1);

    // bad checksum
    clear_log();
    send(8'h03, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h67, 0);
    chk("bad_error", 32'(error), 1);
    chk("bad_cpu_rstn", 32'(cpu_rstn), 0);
    chk("bad_in_ready", 32'(in_ready), 0);
    chk("bad_done", 32'(done), 0);
    check_abc("bad", 1);
    repeat (3) @(posedge clk);
    #1;
    chk("bad_sticky", 32'(error), 1);

    // length zero
    pulse_start();
    chk("l0_error_clr", 32'(error), 0);
    clear_log();
    send(8'h00, 0);
    chk("l0_error", 32'(error), 1);
    chk("l0_nwr", wa.size(), 0);

    // length DEPTH+1
    pulse_start();
    send(8'h11, 0);
    chk("l17_error", 32'(error), 1);
    chk("l17_nwr", wa.size(), 0);

    // length DEPTH fills every address
    pulse_start();
    clear_log();
    send(8'h10, 0);
    for (int i = 0; i < 16; i++) send(8'h01, 0);
    send(8'h10, 0);
    chk("l16_done", 32'(done), 1);
    chk("l16_nwr", wa.size(), 16);
    if (wa.size() == 16) begin
      chk("l16_last_addr", 32'(wa[15]), 15);
      chk("l16_last_data", 32'(wd[15]), 1);
    end

    // stalled stream, one idle cycle between beats
    pulse_start();
    clear_log();
    send(8'h03, 1); send(8'h11, 1); send(8'h22, 1); send(8'h33, 1); send(8'h66, 1);
    chk("stall_done", 32'(done), 1);
    check_abc("stall", 2);

    // restart mid-DATA with a beat held valid in the start cycle
    pulse_start();
    clear_log();
    send(8'h03, 0); send(8'h11, 0); send(8'h22, 0);
    in_valid = 1'b1;
    in_data  = 8'h33;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    chk("rst_mid_ready", 32'(in_ready), 1);
    send(8'h01, 0); send(8'hAA, 0); send(8'hAA, 0);
    chk("rst_mid_done", 32'(done), 1);
    chk("rst_mid_nwr", wa.size(), 3);
    if (wa.size() == 3) begin
      chk("rst_mid_addr2", 32'(wa[2]), 0);
      chk("rst_mid_data2", 32'(wd[2]), 32'h0AA);
    end

    // async reset in DATA while a write is in flight
    pulse_start();
    send(8'h03, 0); send(8'h11, 0);
    chk("ar_we_pre", 32'(mem_we), 1);
    #2 rstn = 1'b0;
    #1;
    chk("ar_we", 32'(mem_we), 0);
    chk("ar_cpu_rstn", 32'(cpu_rstn), 0);
    chk("ar_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_idle_ready", 32'(in_ready), 0);
    chk("ar_idle_addr", 32'(mem_addr), 0);

    // async reset while running drops cpu_rstn at once
    pulse_start();
    send(8'h03, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h66, 0);
    chk("ar_run_pre", 32'(cpu_rstn), 1);
    #2 rstn = 1'b0;
    #1;
    chk("ar_run_cpu_rstn", 32'(cpu_rstn), 0);
    chk("ar_run_done", 32'(done), 0);
    @(negedge clk);
    rstn = 1'b1;
    clear_log();
    in_valid = 1'b1;
    in_data  = 8'h05;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("ar_run_idle_ready", 32'(in_ready), 0);
    chk("ar_run_idle_nwr", wa.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
